// File: rtl/ovf_fifo_push_arbiter_if.sv
// ovf_fifo_push_arbiter_if: producer/consumer/FIFO-side bundle of the overflow FIFO push arbiter
//   flush, overwrite_en, clr_drop : control into the arbiter
//   req_valid/req_data/req_ready  : per-requester zero-cycle handshake, req_ready is the one-hot grant
//   cons_pop                      : consumer pop request
//   fifo_flush/push/push_data/pop : drive the attached FIFO
//   occ/full/empty/drop_cnt       : occupancy status and saturating overwrite-drop count
interface ovf_fifo_push_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
);
   logic                          flush;
   logic                          overwrite_en;
   logic                          clr_drop;
   logic [N_REQ-1:0]              req_valid;
   logic [N_REQ-1:0][DW-1:0]      req_data;
   logic [N_REQ-1:0]              req_ready;
   logic                          cons_pop;
   logic                          fifo_flush;
   logic                          fifo_push;
   logic [DW-1:0]                 fifo_push_data;
   logic                          fifo_pop;
   logic [$clog2(DEPTH+1)-1:0]    occ;
   logic                          full;
   logic                          empty;
   logic [CNT_W-1:0]              drop_cnt;
   modport master (
      output flush, overwrite_en, clr_drop, req_valid, req_data, cons_pop,
      input  req_ready, fifo_flush, fifo_push, fifo_push_data, fifo_pop, occ, full, empty, drop_cnt
   );
   modport slave (
      input  flush, overwrite_en, clr_drop, req_valid, req_data, cons_pop,
      output req_ready, fifo_flush, fifo_push, fifo_push_data, fifo_pop, occ, full, empty, drop_cnt
   );
endinterface

// File: rtl/ovf_fifo_push_arbiter.sv
// ovf_fifo_push_arbiter: round-robin push arbiter and occupancy tracker for a shared overflow FIFO
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of ovf_fifo_push_arbiter_if (requesters, consumer pop, FIFO controls, status)
module ovf_fifo_push_arbiter #(
   parameter int N_REQ = 4,
   parameter int DW    = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic                   clk,
   input logic                   rst,
   ovf_fifo_push_arbiter_if.slave bus
);
   localparam int OW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(N_REQ);
   localparam logic [OW-1:0] OCC_FULL = OW'(DEPTH);
   logic [OW-1:0]    r_occ;
   logic [PW-1:0]    r_rr_ptr;
   logic [CNT_W-1:0] r_drop_cnt;
   logic             w_accept;
   logic             w_any;
   logic             w_hit_hi;
   logic [PW-1:0]    w_lo;
   logic [PW-1:0]    w_hi;
   logic [PW-1:0]    w_gidx;
   logic             w_push;
   logic             w_pop;
   logic             w_drop;
   // rst gating keeps req_ready at its reset value while reset is held, even with valids pending
   assign w_accept = ~rst & ~bus.flush & (bus.overwrite_en | (r_occ < OCC_FULL));
   // descending scan leaves the lowest valid index overall (w_lo) and the lowest at or above rr_ptr (w_hi)
   always_comb begin
      w_any    = 1'b0;
      w_hit_hi = 1'b0;
      w_lo     = '0;
      w_hi     = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            w_any = 1'b1;
            w_lo  = PW'(i);
            if (PW'(i) >= r_rr_ptr) begin
               w_hit_hi = 1'b1;
               w_hi     = PW'(i);
            end
         end
      end
      w_gidx = w_hit_hi ? w_hi : w_lo;
   end
   assign w_push             = w_accept & w_any;
   assign w_pop              = bus.cons_pop & (r_occ != '0) & ~bus.flush;
   assign w_drop             = w_push & ~w_pop & (r_occ == OCC_FULL);
   assign bus.req_ready      = w_push ? (N_REQ'(1) << w_gidx) : '0;
   assign bus.fifo_push      = w_push;
   assign bus.fifo_push_data = w_push ? bus.req_data[w_gidx] : '0;
   assign bus.fifo_pop       = w_pop;
   assign bus.fifo_flush     = bus.flush;
   assign bus.occ            = r_occ;
   assign bus.full           = r_occ == OCC_FULL;
   assign bus.empty          = r_occ == '0;
   assign bus.drop_cnt       = r_drop_cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ      <= '0;
         r_rr_ptr   <= '0;
         r_drop_cnt <= '0;
      end else begin
         if (bus.flush) begin
            r_occ    <= '0;
            r_rr_ptr <= '0;
         end else begin
            if (w_push) r_rr_ptr <= (w_gidx == PW'(N_REQ - 1)) ? '0 : w_gidx + PW'(1);
            // push at full in lossy mode overwrites the oldest entry, so occupancy holds at DEPTH
            if (w_push & ~w_pop & (r_occ != OCC_FULL)) r_occ <= r_occ + OW'(1);
            else if (~w_push & w_pop) r_occ <= r_occ - OW'(1);
         end
         if (bus.clr_drop) r_drop_cnt <= '0;
         else if (w_drop & ~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_ovf_fifo_push_arbiter.sv
// tb_ovf_fifo_push_arbiter: directed plus randomized check of the push arbiter against a queue-based FIFO model
module tb_ovf_fifo_push_arbiter;
   localparam int N = 4, DW = 16, DEPTH = 4, CNT_W = 16;
   logic clk = 1'b0;
   logic rst;
   int n_cmp = 0, n_err = 0;
   logic [DW-1:0] q[$];
   int rr = 0;
   int unsigned drop = 0;
   always #5 clk = ~clk;
   ovf_fifo_push_arbiter_if #(.N_REQ(N), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();
   ovf_fifo_push_arbiter #(.N_REQ(N), .DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus.slave)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input logic [N-1:0] v, input logic ow, input logic pop, input logic fl, input logic clr);
      bus.req_valid    = v;
      bus.overwrite_en = ow;
      bus.cons_pop     = pop;
      bus.flush        = fl;
      bus.clr_drop     = clr;
      for (int i = 0; i < N; i++) bus.req_data[i] = DW'($urandom);
      #1;
   endtask
   task automatic cyc();
      int g;
      bit acc, pop;
      logic [N-1:0] rdy;
      logic [DW-1:0] d;
      g   = -1;
      acc = !bus.flush && (bus.overwrite_en || q.size() < DEPTH);
      if (acc)
         for (int k = 0; k < N; k++)
            if (g < 0 && bus.req_valid[(rr + k) % N]) g = (rr + k) % N;
      rdy = (g >= 0) ? N'(1) << g : '0;
      d   = (g >= 0) ? bus.req_data[g] : '0;
      pop = bus.cons_pop && q.size() > 0 && !bus.flush;
      chk("req_ready", 64'(bus.req_ready), 64'(rdy));
      chk("fifo_push", 64'(bus.fifo_push), 64'(g >= 0));
      chk("push_data", 64'(bus.fifo_push_data), 64'(d));
      chk("fifo_pop", 64'(bus.fifo_pop), 64'(pop));
      chk("fifo_flush", 64'(bus.fifo_flush), 64'(bus.flush));
      chk("occ", 64'(bus.occ), 64'(q.size()));
      chk("full", 64'(bus.full), 64'(q.size() == DEPTH));
      chk("empty", 64'(bus.empty), 64'(q.size() == 0));
      chk("drop_cnt", 64'(bus.drop_cnt), 64'(drop));
      begin
         bit dropped = 0;
         if (bus.flush) begin
            q.delete();
            rr = 0;
         end else begin
            if (pop) void'(q.pop_front());
            if (g >= 0) begin
               if (q.size() == DEPTH) begin
                  void'(q.pop_front());
                  dropped = 1;
               end
               q.push_back(d);
               rr = (g + 1) % N;
            end
         end
         if (bus.clr_drop) drop = 0;
         else if (dropped && drop != (2 ** CNT_W) - 1) drop++;
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b1;
      bus.req_valid = '0; bus.req_data = '0; bus.overwrite_en = 0;
      bus.cons_pop = 0; bus.flush = 0; bus.clr_drop = 0;
      #12;
      chk("rst_occ", 64'(bus.occ), 0);
      chk("rst_empty", 64'(bus.empty), 1);
      chk("rst_full", 64'(bus.full), 0);
      chk("rst_ready", 64'(bus.req_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      // 1: fill in round-robin order, then blocked at full
      for (int i = 0; i < 4; i++) begin
         drive(4'b1111, 0, 0, 0, 0);
         chk("t1_grant", 64'(bus.req_ready), 64'(1 << i));
         cyc();
      end
      drive(4'b1111, 0, 0, 0, 0);
      chk("t1_occ", 64'(bus.occ), 4);
      chk("t1_full", 64'(bus.full), 1);
      chk("t1_blocked", 64'(bus.req_ready), 0);
      cyc();
      // 2: pop at full does not free a slot the same cycle
      drive(4'b1111, 0, 1, 0, 0);
      chk("t2_noready", 64'(bus.req_ready), 0);
      chk("t2_pop", 64'(bus.fifo_pop), 1);
      cyc();
      drive(4'b1111, 0, 0, 0, 0);
      chk("t2_occ3", 64'(bus.occ), 3);
      chk("t2_grant0", 64'(bus.req_ready), 1);
      cyc();
      drive(0, 0, 0, 0, 0);
      chk("t2_occ4", 64'(bus.occ), 4);
      // 3: lossy overwrite counts drops; clr_drop beats a concurrent drop
      for (int i = 0; i < 3; i++) begin
         drive(4'b0100, 1, 0, 0, 0);
         chk("t3_grant2", 64'(bus.req_ready), 4);
         cyc();
      end
      drive(4'b0100, 1, 0, 0, 1);
      chk("t3_occ", 64'(bus.occ), 4);
      chk("t3_drop", 64'(bus.drop_cnt), 3);
      cyc();
      drive(0, 0, 0, 0, 0);
      chk("t3_clr", 64'(bus.drop_cnt), 0);
      // 4: push+pop keeps occupancy; pop while empty is ignored
      for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0, 0); cyc(); end
      drive(4'b0001, 0, 1, 0, 0);
      chk("t4_occ2", 64'(bus.occ), 2);
      chk("t4_push", 64'(bus.fifo_push), 1);
      chk("t4_pop", 64'(bus.fifo_pop), 1);
      cyc();
      for (int i = 0; i < 2; i++) begin drive(0, 0, 1, 0, 0); cyc(); end
      drive(0, 0, 1, 0, 0);
      chk("t4_empty_pop", 64'(bus.fifo_pop), 0);
      cyc();
      drive(0, 0, 0, 0, 0);
      chk("t4_occ0", 64'(bus.occ), 0);
      // 5: flush at occ=3, rr_ptr=2
      for (int i = 0; i < 3; i++) begin drive(4'b0010, 0, 0, 0, 0); cyc(); end
      drive(4'b1111, 0, 1, 1, 0);
      chk("t5_ready", 64'(bus.req_ready), 0);
      chk("t5_pop", 64'(bus.fifo_pop), 0);
      chk("t5_flush", 64'(bus.fifo_flush), 1);
      cyc();
      drive(4'b1111, 0, 0, 0, 0);
      chk("t5_occ", 64'(bus.occ), 0);
      chk("t5_rr0", 64'(bus.req_ready), 1);
      cyc();
      // 6: reach occ=3, drop_cnt=5, then asynchronous reset mid-cycle
      for (int i = 0; i < 8; i++) begin drive(4'b1111, 1, 0, 0, 0); cyc(); end
      drive(0, 0, 1, 0, 0); cyc();
      drive(4'b1111, 0, 0, 0, 0);
      chk("t6_occ3", 64'(bus.occ), 3);
      chk("t6_drop5", 64'(bus.drop_cnt), 5);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_occ", 64'(bus.occ), 0);
      chk("t6_drop", 64'(bus.drop_cnt), 0);
      chk("t6_empty", 64'(bus.empty), 1);
      chk("t6_ready", 64'(bus.req_ready), 0);
      chk("t6_push", 64'(bus.fifo_push), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      q.delete(); rr = 0; drop = 0;
      // random traffic against the queue model
      for (int c = 0; c < 600; c++) begin
         drive(N'($urandom), ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 19) == 0), ($urandom_range(0, 29) == 0));
         cyc();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ovf_fifo_push_arbiter.md
Name: ovf_fifo_push_arbiter

Overview:
Round-robin arbiter and occupancy controller that shares one overflow FIFO (one-hot pointers, oldest entry dropped on push-when-full) between N_REQ producers.
- Grants at most one producer per cycle and drives the FIFO push and data.
- Gates consumer pops and tracks FIFO occupancy.
- Two modes, selected by overwrite_en:
  - Lossless (overwrite_en=0): applies credit backpressure so the FIFO never overflows.
  - Lossy (overwrite_en=1): lets the FIFO overwrite and counts the dropped entries.

Parameters:
N_REQ, 4, number of requesters (>=2)
DW, 16, data width
DEPTH, 4, FIFO depth; must equal the attached FIFO's DEPTH (>=2)
CNT_W, 16, drop counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous flush request
overwrite_en  in  1  0 = lossless/backpressure, 1 = lossy/overwrite
req_valid  in  N_REQ  per-requester valid
req_data  in  N_REQ x DW  per-requester data, packed, index i at [i]
req_ready  out  N_REQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
cons_pop  in  1  consumer pop request
fifo_flush  out  1  to FIFO flush
fifo_push  out  1  to FIFO push
fifo_push_data  out  DW  to FIFO push_data
fifo_pop  out  1  to FIFO pop
occ  out  $clog2(DEPTH+1)  current FIFO occupancy, registered
full  out  1  occ == DEPTH
empty  out  1  occ == 0
drop_cnt  out  CNT_W  saturating count of entries lost to overwrite
clr_drop  in  1  synchronous clear of drop_cnt

Behaviour:
- Reset values:
  - occ=0, rr_ptr=0, drop_cnt=0.
  - Hence empty=1, full=0, req_ready=0, fifo_push=0, fifo_pop=0, fifo_flush=0.
- Datapath outputs are combinational from registered state plus inputs:
  - fifo_flush = flush.
  - fifo_push_data = req_data[granted index]; all zeros when there is no grant.
- Accept condition:
  - accept = ~flush & (overwrite_en | occ < DEPTH).
  - A push-side pop in the same cycle does NOT free a slot for acceptance. There is no combinational path from cons_pop to req_ready.
- Grant:
  - When accept is true, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - req_ready = one-hot of the granted index; zero when there is no grant.
  - fifo_push = |req_ready (valid & ready).
  - Zero-cycle handshake; data lands in the FIFO at the next clk edge.
  - req_ready depends on req_valid. A requester must hold valid and data until it is granted.
- rr_ptr update:
  - On a grant to index g, rr_ptr <= (g+1) mod N_REQ.
  - Unchanged with no grant.
  - Cleared to 0 on flush.
- Pop gating: fifo_pop = cons_pop & (occ != 0) & ~flush. A pop while empty is ignored and has no effect.
- Occupancy update, flush has priority:
  - flush: occ <= 0. Pending requests are not granted that cycle.
  - push & fifo_pop: occ unchanged.
  - push only, occ < DEPTH: occ+1.
  - push only, occ == DEPTH (lossy mode only): occ stays DEPTH; drop_cnt+1, saturating at all-ones.
  - fifo_pop only: occ-1.
- drop_cnt:
  - Cleared by clr_drop, which has priority over increment in the same cycle.
  - Not cleared by flush.
- Mode switch:
  - overwrite_en may change on any cycle and takes effect that cycle.
  - Switching 1->0 while full immediately deasserts all req_ready.
- Reset asserted mid-transfer: all state is cleared asynchronously; the in-flight push is not counted.
- Invariant: occ equals the attached FIFO's entry count at all times, given a shared clk/rst and an identical DEPTH.

Test Plan:
1. Reset, then req_valid=4'b1111 held for 4 cycles, DEPTH=4, overwrite_en=0, no pops -> grants in order 0,1,2,3; occ=4, full=1; 5th cycle req_ready=0.
2. Continuing from full, lossless: cons_pop=1 for 1 cycle with req_valid=1111 -> no grant that cycle (fifo_pop=1); occ=3 next cycle; following cycle grants requester 0 (rr_ptr=0) and occ=4.
3. Lossy: overwrite_en=1, occ=4, req_valid=4'b0100 for 3 cycles, no pop -> 3 grants to index 2; occ stays 4; drop_cnt=3. Then clr_drop=1 with a concurrent overflowing push -> drop_cnt=0.
4. Simultaneous push+pop at occ=2 -> occ stays 2 and fifo_push=fifo_pop=1. cons_pop at occ=0 -> fifo_pop=0 and occ stays 0.
5. Flush at occ=3 with req_valid=1111, rr_ptr=2, cons_pop=1 -> req_ready=0, fifo_pop=0, fifo_flush=1; next cycle occ=0, rr_ptr=0, drop_cnt unchanged.
6. Async rst asserted mid-cycle at occ=3, drop_cnt=5 -> outputs return to reset values immediately without waiting for clk. Scoreboard against the FIFO model confirms occ matches the FIFO entry count through random push/pop/flush.
